// File: rtl/line_delay_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_delay_buffer : multi-lane, valid-gated, runtime-depth delay line
// Revision 1.0
// ----------------------------------------------------------------------------
module line_delay_buffer #(
  parameter  int WIDTH     = 16,
  parameter  int CHANNELS  = 3,
  parameter  int MAX_DEPTH = 64,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_load,
  input  logic [DEPTH_W-1:0]           cfg_depth,
  input  logic                         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]    din,
  output logic                         out_valid,
  output logic [CHANNELS*WIDTH-1:0]    dout,
  output logic                         primed,
  output logic [DEPTH_W-1:0]           fill_count
);

  localparam int                 PTR_W       = $clog2(MAX_DEPTH);
  localparam int                 DATA_W      = CHANNELS * WIDTH;
  localparam logic [DEPTH_W-1:0] C_MAX_DEPTH = DEPTH_W'(MAX_DEPTH);

  logic [DATA_W-1:0]  mem [MAX_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [DEPTH_W-1:0] depth_q,      depth_d;
  logic [DEPTH_W-1:0] fill_count_q, fill_count_d;
  logic               primed_q,     primed_d;
  logic               out_valid_q,  out_valid_d;
  logic [DATA_W-1:0]  dout_q,       dout_d;

  logic w_accept;
  logic w_last_slot;

  assign w_accept    = in_valid & ~cfg_load;
  assign w_last_slot = ({1'b0, wr_ptr_q} == (depth_q - DEPTH_W'(1)));

  always_comb begin
    depth_d      = depth_q;
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    primed_d     = primed_q;
    out_valid_d  = 1'b0;
    dout_d       = dout_q;
    if (cfg_load) begin
      if (cfg_depth == '0) begin
        depth_d = DEPTH_W'(1);
      end else if (cfg_depth > C_MAX_DEPTH) begin
        depth_d = C_MAX_DEPTH;
      end else begin
        depth_d = cfg_depth;
      end
      wr_ptr_d     = '0;
      fill_count_d = '0;
      primed_d     = 1'b0;
    end else if (in_valid) begin
      wr_ptr_d = w_last_slot ? '0 : wr_ptr_q + 1'b1;
      // Read-before-write: the slot about to be overwritten holds the sample D beats old.
      if (primed_q) begin
        out_valid_d = 1'b1;
        dout_d      = mem[wr_ptr_q];
      end else begin
        fill_count_d = fill_count_q + 1'b1;
        primed_d     = ((fill_count_q + 1'b1) == depth_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      depth_q      <= C_MAX_DEPTH;
      fill_count_q <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      depth_q      <= depth_d;
      fill_count_q <= fill_count_d;
      primed_q     <= primed_d;
      out_valid_q  <= out_valid_d;
      dout_q       <= dout_d;
    end
  end

  // Storage is never reset; stale entries are masked by the primed gating.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign out_valid  = out_valid_q;
  assign dout       = dout_q;
  assign primed     = primed_q;
  assign fill_count = fill_count_q;

endmodule
`default_nettype wire
